// File: rtl/result_accumulator_pkg.sv
// Shared definitions for the result accumulator slice.
//   - acc_state_e     : FSM state encoding (idle, accumulating, holding a result)
//   - DataWDefault    : default sample/sum datapath width
//   - BlockLenDefault : default number of samples per output block
package result_accumulator_pkg;

    localparam int unsigned DataWDefault    = 32;
    localparam int unsigned BlockLenDefault = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/acc_add_sat.sv
// Adder for the result accumulator: sums the running total with a new sample and
// reports carry-out. With RESULT_ACCUMULATOR_SATURATE_EN defined, a carry clamps the
// result to all-ones; otherwise the result wraps modulo 2^DATA_W.
//
// Ports:
//   a_i     [DATA_W-1:0]  running sum
//   b_i     [DATA_W-1:0]  incoming sample
//   sum_o   [DATA_W-1:0]  next running sum (wrapped or saturated)
//   carry_o               carry-out of the unsaturated add
module acc_add_sat
    import result_accumulator_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o
);

    logic [DATA_W:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o  = full_sum[DATA_W];

`ifdef RESULT_ACCUMULATOR_SATURATE_EN
    // Once clamped, any further non-zero add carries again, so the sum stays
    // pinned at all-ones for the rest of the block.
    assign sum_o = carry_o ? {DATA_W{1'b1}} : full_sum[DATA_W-1:0];
`else
    assign sum_o = full_sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/result_accumulator.sv
// Block result accumulator: sums BLOCK_LEN accepted samples, then holds the sum and
// a sticky overflow flag until the consumer takes it. clear aborts the current block.
// Optional macro RESULT_ACCUMULATOR_SATURATE_EN selects saturating instead of
// wrapping addition (implemented in acc_add_sat).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous abort of the current block (highest priority)
//   in_y       sample input, in_valid qualifies it, in_ready accepts it
//   out_sum    completed block sum (0 unless out_valid)
//   out_ovf    completed block overflowed (0 unless out_valid)
//   out_valid  result is presented, out_ready takes it
//   busy       block partially accumulated or result being held
module result_accumulator
    import result_accumulator_pkg::*;
#(
    parameter int unsigned BLOCK_LEN = BlockLenDefault,
    parameter int unsigned DATA_W    = DataWDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    // BLOCK_LEN is at most 255, so an 8-bit count always suffices.
    localparam int unsigned CntW    = 8;
    localparam logic [CntW-1:0] LastCnt = CntW'(BLOCK_LEN - 1);

    acc_state_e        state_q, state_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] add_sum;
    logic              add_carry;
    logic              xfer;

    acc_add_sat #(
        .DATA_W (DATA_W)
    ) u_add (
        .a_i     (sum_q),
        .b_i     (in_y),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Ready is a pure function of registered state.
    assign in_ready  = (state_q != StHold);
    assign xfer      = in_valid && in_ready;
    assign out_valid = (state_q == StHold);
    assign out_sum   = out_valid ? sum_q : '0;
    assign out_ovf   = out_valid ? ovf_q : 1'b0;
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = StIdle;
            sum_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        state_d = StAccum;
                        sum_d   = in_y;
                        count_d = CntW'(1);
                        ovf_d   = 1'b0;
                    end
                end
                StAccum: begin
                    if (xfer) begin
                        sum_d   = add_sum;
                        count_d = count_q + CntW'(1);
                        ovf_d   = ovf_q | add_carry;
                        if (count_q == LastCnt) begin
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_d = StIdle;
                        sum_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    sum_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_result_accumulator.sv
// Self-checking bench for result_accumulator: directed block scenarios followed by
// randomized traffic, all checked every cycle against a block-level reference model
// (list of accepted samples, result from their plain arithmetic total).
module tb_result_accumulator;

    localparam int unsigned BlockLen = 8;
    localparam int unsigned DataW    = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [DataW-1:0] in_y;
    logic             in_valid;
    logic             in_ready;
    logic [DataW-1:0] out_sum;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state
    logic [DataW-1:0] m_q[$];
    bit               m_hold;
    logic [DataW-1:0] m_sum;
    bit               m_ovf;

    always #5 clk = ~clk;

    result_accumulator #(
        .BLOCK_LEN (BlockLen),
        .DATA_W    (DataW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_y      (in_y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Block result from the accepted samples: true total in 64 bits, then wrap or clamp.
    task automatic model_finish_block();
        longint unsigned total = 0;
        foreach (m_q[i]) total += 64'(m_q[i]);
        m_ovf = (total > 64'h0000_0000_FFFF_FFFF);
`ifdef RESULT_ACCUMULATOR_SATURATE_EN
        m_sum = m_ovf ? 32'hFFFF_FFFF : total[31:0];
`else
        m_sum = total[31:0];
`endif
        m_hold = 1'b1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_hold = 1'b0;
        m_sum  = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("in_ready", 64'(in_ready), 64'(!m_hold));
        check_eq("out_valid", 64'(out_valid), 64'(m_hold));
        check_eq("busy", 64'(busy), 64'(m_hold || (m_q.size() > 0)));
        check_eq("out_sum", 64'(out_sum), m_hold ? 64'(m_sum) : 64'h0);
        check_eq("out_ovf", 64'(out_ovf), m_hold ? 64'(m_ovf) : 64'h0);
    endtask

    // Called at posedge+1: check current outputs, drive inputs, advance model and clock.
    task automatic cycle(input bit v, input logic [DataW-1:0] y, input bit ordy, input bit clr);
        check_outputs();
        in_valid  = v;
        in_y      = y;
        out_ready = ordy;
        clear     = clr;
        if (clr) begin
            model_reset();
        end else if (m_hold) begin
            if (ordy) model_reset();
        end else if (v) begin
            m_q.push_back(y);
            if (m_q.size() == BlockLen) model_finish_block();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'h1);
        check_eq({tag, "_out_valid"}, 64'(out_valid), 64'h0);
        check_eq({tag, "_out_sum"}, 64'(out_sum), 64'h0);
        check_eq({tag, "_out_ovf"}, 64'(out_ovf), 64'h0);
        check_eq({tag, "_busy"}, 64'(busy), 64'h0);
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic apply_reset(input string tag);
        in_valid  = 1'b1;
        in_y      = 32'h5;
        out_ready = 1'b0;
        clear     = 1'b0;
        rst       = 1'b1;
        #2;
        check_reset_outputs({tag, "_async"});
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    function automatic logic [DataW-1:0] rand_sample();
        logic [DataW-1:0] s;
        case ($urandom_range(0, 4))
            0:       s = 32'h0;
            1:       s = 32'h1;
            2:       s = 32'h8000_0000;
            3:       s = 32'hFFFF_FFFF;
            default: s = $urandom;
        endcase
        return s;
    endfunction

    logic [DataW-1:0] vec034[8];

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_y      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #3;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Eight ones: result visible exactly one cycle after the 8th transfer.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check_eq("req033_pre_valid", 64'(out_valid), 64'h0);
            cycle(1'b1, 32'h1, 1'b0, 1'b0);
        end
        check_eq("req033_valid", 64'(out_valid), 64'h1);
        check_eq("req033_sum", 64'(out_sum), 64'h8);
        check_eq("req033_ovf", 64'(out_ovf), 64'h0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Mixed samples, with idle gaps inside the block.
        vec034 = '{32'h1, 32'h1000, 32'h1000_0000, 32'h0,
                   32'h1, 32'h1000, 32'h1000_0000, 32'h1};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vec034[i], 1'b0, 1'b0);
            if (i == 3) cycle(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        end
        check_eq("req034_sum", 64'(out_sum), 64'h2000_2003);
        check_eq("req034_ovf", 64'(out_ovf), 64'h0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Overflow: wrap or saturate depending on build.
        for (int i = 0; i < 8; i++) cycle(1'b1, (i < 2) ? 32'h8000_0000 : 32'h0, 1'b0, 1'b0);
`ifdef RESULT_ACCUMULATOR_SATURATE_EN
        check_eq("req035_sum", 64'(out_sum), 64'hFFFF_FFFF);
`else
        check_eq("req035_sum", 64'(out_sum), 64'h0);
`endif
        check_eq("req035_ovf", 64'(out_ovf), 64'h1);

        // Backpressure in HOLD with samples offered: nothing absorbed, result stable.
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, 32'h7, 1'b1, 1'b0);
        check_eq("req036_in_ready", 64'(in_ready), 64'h1);
        check_eq("req036_busy", 64'(busy), 64'h0);

        // Reset mid-block discards the partial sum.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h5, 1'b0, 1'b0);
        apply_reset("req037_rst");
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h2, 1'b0, 1'b0);
        check_eq("req037_sum", 64'(out_sum), 64'h10);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Clear with a coincident sample in ACCUM, then in HOLD.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3, 1'b0, 1'b0);
        cycle(1'b1, 32'h9, 1'b0, 1'b1);
        check_eq("req038_accum_busy", 64'(busy), 64'h0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h4, 1'b0, 1'b0);
        check_eq("req038_hold_valid", 64'(out_valid), 64'h1);
        cycle(1'b1, 32'h9, 1'b1, 1'b1);
        check_eq("req038_hold_valid_fall", 64'(out_valid), 64'h0);
        check_eq("req038_hold_busy", 64'(busy), 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset("rand_rst");
            end else begin
                cycle($urandom_range(0, 3) != 0, rand_sample(),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
            end
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
